mc_decoder: RTL and testbench
=============================

MC_DECODER -- requirements
Module: mc_decoder

Interface
REQ-001 The module SHALL have: clk  in  1  rising-edge clock.
REQ-002 The module SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 The module SHALL have: Op  in  2  instruction bits [27:26].
REQ-004 The module SHALL have: Funct  in  6  instruction bits [25:20] (I, cmd[3:0], S/L).
REQ-005 The module SHALL have: Rd  in  4  destination register field.
REQ-006 The module SHALL have: FlagW  out  2  flag write request to the condition stage, where [1] is NZ and [0] is CV.
REQ-007 The module SHALL have: PCS, RegW, MemW, NoWrite  out  1 each  unconditioned write requests to the condition stage.
REQ-008 The module SHALL have: NextPC, IRWrite, AdrSrc  out  1 each  PC update, IR load and memory-address select.
REQ-009 The module SHALL have: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.

Function
REQ-010 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH and UNKNOWN, and SHALL advance one state per clock.
REQ-011 Transitions SHALL be: FETCH->DECODE; MEMRD->MEMWB; MEMADR->MEMRD if Funct[0]=1, else MEMWR; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN->FETCH.
REQ-012 DECODE SHALL go to MEMADR when Op=01, EXECR when Op=00 and Funct[5]=0, EXECI when Op=00 and Funct[5]=1, BRANCH when Op=10, and UNKNOWN when Op=11.
REQ-013 Moore outputs SHALL be: FETCH IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; DECODE ALUSrcA=01, ALUSrcB=10, ResultSrc=10; MEMADR ALUSrcA=00, ALUSrcB=01.
REQ-014 Moore outputs SHALL further be: MEMRD AdrSrc=1, ResultSrc=00; MEMWB RegW=1, ResultSrc=01; MEMWR AdrSrc=1, MemW=1, ResultSrc=00.
REQ-015 Moore outputs SHALL further be: EXECR ALUSrcA=00, ALUSrcB=00, ALUOp=1; EXECI ALUSrcA=00, ALUSrcB=01, ALUOp=1; ALUWB RegW=1, ResultSrc=00; BRANCH ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-016 Any Moore output not listed for a state SHALL be 0; UNKNOWN SHALL drive all Moore outputs to 0.
REQ-017 When ALUOp=1, ALUControl SHALL decode Funct[4:1] as follows: 0100 ADD gives 00, 0010 SUB gives 01, 0000 AND gives 10, 1100 ORR gives 11, 1010 CMP gives 01 with NoWrite=1, and any other value gives 00 with FlagW=00.
REQ-018 When ALUOp=1 and the command is decoded, FlagW[1] SHALL equal Funct[0], and FlagW[0] SHALL equal Funct[0] AND (ALUControl is 00 or 01).
REQ-019 When ALUOp=0, ALUControl SHALL be 00, FlagW SHALL be 00 and NoWrite SHALL be 0.
REQ-020 PCS SHALL equal (Rd=1111 AND RegW) OR Branch, combinationally.
REQ-021 ImmSrc SHALL equal Op, RegSrc[0] SHALL equal (Op=10), and RegSrc[1] SHALL equal (Op=01), all combinationally and in every state.
REQ-022 Latencies SHALL be: data-processing 4 cycles, LDR 5 cycles, STR 4 cycles, B 3 cycles, undefined 3 cycles.

Reset
REQ-023 Asserting reset SHALL asynchronously force the state to FETCH.
REQ-024 While reset is high, IRWrite, NextPC, RegW, MemW and PCS SHALL be 0; all other outputs SHALL take their FETCH values.
REQ-025 On the first rising edge after reset deasserts, the block SHALL perform a full FETCH (IRWrite=1, NextPC=1) and move to DECODE on the following edge.
REQ-026 Reset asserted in any state mid-instruction SHALL abandon the instruction with no further RegW, MemW or PCS pulse.

Verification
REQ-027 ADDS R1 (Op=00, Funct=001001, Rd=0001) -> FETCH, DECODE, EXECR, ALUWB; in EXECR ALUControl=00 and FlagW=11; in ALUWB RegW=1 and PCS=0.
REQ-028 LDR (Op=01, Funct=011001) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (RegW=1, ResultSrc=01), then FETCH; RegSrc=10.
REQ-029 STR (Op=01, Funct=011000) -> MEMADR, MEMWR with MemW=1 for exactly one cycle, then FETCH.
REQ-030 B (Op=10) -> BRANCH with PCS=1, ALUSrcA=10 and ALUSrcB=01; ADD with Rd=1111 -> PCS=1 in ALUWB.
REQ-031 CMP (Op=00, Funct=110101) -> EXECI with ALUControl=01, NoWrite=1, FlagW=11; Op=11 -> UNKNOWN with all write outputs 0, then FETCH.
REQ-032 Reset pulsed mid-cycle while in MEMWR -> MemW drops to 0 immediately, state is FETCH, and IRWrite=0 until reset releases.

Source files
------------

// File: rtl/mc_decoder.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder and PC logic.
module mc_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  localparam int unsigned STATE_W = 4;
  localparam logic [3:0]  RD_PC   = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    UNKNOWN = 4'd10
  } state_t;

  state_t state, state_next;

  // Raw Moore controls before reset gating
  logic alu_op, branch, regw_st, memw_st, irwrite_st, nextpc_st;
  logic cmd_ok;

  // State register; reset parks the machine in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next = state;
    alu_op     = 1'b0;
    branch     = 1'b0;
    regw_st    = 1'b0;
    memw_st    = 1'b0;
    irwrite_st = 1'b0;
    nextpc_st  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    case (state)
      FETCH: begin
        state_next = DECODE;
        irwrite_st = 1'b1;
        nextpc_st  = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        state_next = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB    = 2'b01;
      end
      MEMRD: begin
        state_next = MEMWB;
        AdrSrc     = 1'b1;
      end
      MEMWB: begin
        state_next = FETCH;
        regw_st    = 1'b1;
        ResultSrc  = 2'b01;
      end
      MEMWR: begin
        state_next = FETCH;
        AdrSrc     = 1'b1;
        memw_st    = 1'b1;
      end
      EXECR: begin
        state_next = ALUWB;
        alu_op     = 1'b1;
      end
      EXECI: begin
        state_next = ALUWB;
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
      end
      ALUWB: begin
        state_next = FETCH;
        regw_st    = 1'b1;
      end
      BRANCH: begin
        state_next = FETCH;
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // ALU decoder: operation select, flag-write and compare suppression
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    NoWrite    = 1'b0;
    cmd_ok     = 1'b0;
    if (alu_op) begin
      cmd_ok = 1'b1;
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: begin
          ALUControl = 2'b01;
          NoWrite    = 1'b1;
        end
        default: cmd_ok = 1'b0;
      endcase
      if (cmd_ok) begin
        FlagW[1] = Funct[0];
        FlagW[0] = Funct[0] & ~ALUControl[1];
      end
    end
  end

  // Write strobes are held off while reset is high
  always_comb begin
    IRWrite = irwrite_st & ~reset;
    NextPC  = nextpc_st & ~reset;
    RegW    = regw_st & ~reset;
    MemW    = memw_st & ~reset;
    PCS     = ((Rd == RD_PC) & RegW) | (branch & ~reset);
  end

  // Instruction-field driven selects, independent of state
  always_comb begin
    ImmSrc = Op;
    RegSrc = {Op == 2'b01, Op == 2'b10};
  end

endmodule

// File: tb/tb_mc_decoder.sv
// Self-checking bench for mc_decoder: instruction table plus reset sequences.
module tb_mc_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic       PCS, RegW, MemW, NoWrite, NextPC, IRWrite, AdrSrc;

  mc_decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_UNKNOWN
  } tb_st_t;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowrite, nextpc, irwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, regsrc, alucontrol;
  } exp_t;

  typedef struct packed {
    logic [1:0]     op;
    logic [5:0]     funct;
    logic [3:0]     rd;
    logic [2:0]     len;
    tb_st_t [0:4]   seq;
    logic [1:0]     alu;
    logic [1:0]     fw;
    logic           nw;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  // Expected outputs for one cycle, built from the state's listed Moore values
  function automatic exp_t exp_for(input logic [1:0] op, input logic [3:0] rd, input tb_st_t st,
                                   input logic [1:0] alu, input logic [1:0] fw, input logic nw);
    exp_t e;
    e = '0;
    case (st)
      T_FETCH:  begin e.irwrite = 1; e.nextpc = 1; e.alusrca = 2'b01; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
      T_DECODE: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
      T_MEMADR: begin e.alusrcb = 2'b01; end
      T_MEMRD:  begin e.adrsrc = 1; end
      T_MEMWB:  begin e.regw = 1; e.resultsrc = 2'b01; end
      T_MEMWR:  begin e.adrsrc = 1; e.memw = 1; end
      T_EXECR:  begin e.alucontrol = alu; e.flagw = fw; e.nowrite = nw; end
      T_EXECI:  begin e.alusrcb = 2'b01; e.alucontrol = alu; e.flagw = fw; e.nowrite = nw; end
      T_ALUWB:  begin e.regw = 1; end
      T_BRANCH: begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.resultsrc = 2'b10; end
      default:  e = '0;
    endcase
    e.pcs    = (st == T_BRANCH) || ((st == T_MEMWB || st == T_ALUWB) && rd == 4'hF);
    e.immsrc = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    return e;
  endfunction

  // Outputs while reset is held: FETCH selects, strobes off
  function automatic exp_t reset_exp(input logic [1:0] op);
    exp_t e;
    e = exp_for(op, 4'h0, T_FETCH, 2'b00, 2'b00, 1'b0);
    e.irwrite = 0;
    e.nextpc  = 0;
    return e;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                              input logic [2:0] len, input tb_st_t s2, input tb_st_t s3, input tb_st_t s4,
                              input logic [1:0] alu, input logic [1:0] fw, input logic nw);
    vec_t v;
    v.op = op; v.funct = funct; v.rd = rd; v.len = len;
    v.seq[0] = T_FETCH; v.seq[1] = T_DECODE; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    v.alu = alu; v.fw = fw; v.nw = nw;
    return v;
  endfunction

  task automatic compare(input string name);
    exp_t a, e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      e = sb.pop_front();
      a.flagw = FlagW; a.pcs = PCS; a.regw = RegW; a.memw = MemW; a.nowrite = NoWrite;
      a.nextpc = NextPC; a.irwrite = IRWrite; a.adrsrc = AdrSrc; a.resultsrc = ResultSrc;
      a.alusrca = ALUSrcA; a.alusrcb = ALUSrcB; a.immsrc = ImmSrc; a.regsrc = RegSrc;
      a.alucontrol = ALUControl;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %06h want %06h (flagw pcs regw memw nowr nextpc irw adr res srca srcb imm regsrc aluc)",
                 name, $time, a, e);
      end
    end
  endtask

  // Drive one instruction for n cycles, checking every cycle; starts and ends at a negedge
  task automatic run_vec(input vec_t v, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      Op = v.op; Funct = v.funct; Rd = v.rd;
      sb.push_back(exp_for(v.op, v.rd, v.seq[k], v.alu, v.fw, v.nw));
      #1;
      compare($sformatf("%s_c%0d", name, k));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = mk(2'b00, 6'b001001, 4'h1, 3'd4, T_EXECR,   T_ALUWB, T_FETCH, 2'b00, 2'b11, 1'b0); // ADDS R1
    vecs[1]  = mk(2'b01, 6'b011001, 4'h2, 3'd5, T_MEMADR,  T_MEMRD, T_MEMWB, 2'b00, 2'b00, 1'b0); // LDR
    vecs[2]  = mk(2'b01, 6'b011000, 4'h3, 3'd4, T_MEMADR,  T_MEMWR, T_FETCH, 2'b00, 2'b00, 1'b0); // STR
    vecs[3]  = mk(2'b10, 6'b000000, 4'h0, 3'd3, T_BRANCH,  T_FETCH, T_FETCH, 2'b00, 2'b00, 1'b0); // B
    vecs[4]  = mk(2'b00, 6'b001000, 4'hF, 3'd4, T_EXECR,   T_ALUWB, T_FETCH, 2'b00, 2'b00, 1'b0); // ADD PC
    vecs[5]  = mk(2'b00, 6'b110101, 4'h0, 3'd4, T_EXECI,   T_ALUWB, T_FETCH, 2'b01, 2'b11, 1'b1); // CMP imm
    vecs[6]  = mk(2'b11, 6'b111111, 4'hF, 3'd3, T_UNKNOWN, T_FETCH, T_FETCH, 2'b00, 2'b00, 1'b0); // undefined
    vecs[7]  = mk(2'b00, 6'b000101, 4'h4, 3'd4, T_EXECR,   T_ALUWB, T_FETCH, 2'b01, 2'b11, 1'b0); // SUBS
    vecs[8]  = mk(2'b00, 6'b100001, 4'h5, 3'd4, T_EXECI,   T_ALUWB, T_FETCH, 2'b10, 2'b10, 1'b0); // ANDS imm
    vecs[9]  = mk(2'b00, 6'b011000, 4'h6, 3'd4, T_EXECR,   T_ALUWB, T_FETCH, 2'b11, 2'b00, 1'b0); // ORR
    vecs[10] = mk(2'b00, 6'b000011, 4'h7, 3'd4, T_EXECR,   T_ALUWB, T_FETCH, 2'b00, 2'b00, 1'b0); // EORS, undecoded
    vecs[11] = mk(2'b01, 6'b011001, 4'hF, 3'd5, T_MEMADR,  T_MEMRD, T_MEMWB, 2'b00, 2'b00, 1'b0); // LDR PC

    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'h0;
    #2;
    sb.push_back(reset_exp(2'b00));
    compare("reset_hold");
    @(negedge clk);
    Op = 2'b01; Funct = 6'b011001; Rd = 4'hF;
    sb.push_back(reset_exp(2'b01));
    #1;
    compare("reset_hold_ldr_fields");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i], int'(vecs[i].len), $sformatf("vec%0d", i));

    // Reset mid-MEMWR: store strobe drops at once and FETCH does not fire until release
    run_vec(vecs[2], 3, "str_pre");
    Op = vecs[2].op; Funct = vecs[2].funct; Rd = vecs[2].rd;
    sb.push_back(exp_for(vecs[2].op, vecs[2].rd, T_MEMWR, 2'b00, 2'b00, 1'b0));
    #1;
    compare("str_memwr");
    #1;
    reset = 1'b1;
    sb.push_back(reset_exp(vecs[2].op));
    #1;
    compare("str_reset_mid");
    @(posedge clk);
    @(negedge clk);
    sb.push_back(reset_exp(vecs[2].op));
    #1;
    compare("str_reset_held");
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0], 4, "after_rst_adds");

    // Reset mid-BRANCH kills PCS; machine restarts cleanly
    run_vec(vecs[3], 2, "b_pre");
    Op = vecs[3].op; Funct = vecs[3].funct; Rd = vecs[3].rd;
    sb.push_back(exp_for(vecs[3].op, vecs[3].rd, T_BRANCH, 2'b00, 2'b00, 1'b0));
    #1;
    compare("b_branch");
    #2;
    reset = 1'b1;
    sb.push_back(reset_exp(vecs[3].op));
    #1;
    compare("b_reset_mid");
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[4], 4, "after_rst_addpc");

    // Reset during ALUWB of a PC write suppresses RegW and PCS
    run_vec(vecs[4], 3, "addpc_pre");
    reset = 1'b1;
    sb.push_back(reset_exp(vecs[4].op));
    #1;
    compare("addpc_reset_wb");
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[1], 5, "after_rst_ldr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
